// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates the RF write port between pipeline writeback and a long-latency unit
//   clk/rst                     clock, synchronous active-high reset
//   p_we/p_ad/p_wd/p_stall      pipeline writeback request and hold
//   l_valid/l_ready/l_ad/l_wd   long-latency result handshake
//   iss_valid/iss_ad            long-latency issue, marks destination pending
//   q_ad1/q_ad2/q_busy1/q_busy2 operand pending queries
//   pending_any                 any register pending
//   we3/ad3/wd3                 register file write port
module rf_wb_arbiter #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p_we,
  input  logic [A_WIDTH-1:0] p_ad,
  input  logic [D_WIDTH-1:0] p_wd,
  output logic               p_stall,
  input  logic               l_valid,
  output logic               l_ready,
  input  logic [A_WIDTH-1:0] l_ad,
  input  logic [D_WIDTH-1:0] l_wd,
  input  logic               iss_valid,
  input  logic [A_WIDTH-1:0] iss_ad,
  input  logic [A_WIDTH-1:0] q_ad1,
  input  logic [A_WIDTH-1:0] q_ad2,
  output logic               q_busy1,
  output logic               q_busy2,
  output logic               pending_any,
  output logic               we3,
  output logic [A_WIDTH-1:0] ad3,
  output logic [D_WIDTH-1:0] wd3
);
  typedef enum logic {NORMAL, FORCE} state_t;
  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2**A_WIDTH-1:0] r_pend, w_pend_nxt;
  logic w_claim, w_force, w_grant_p, w_lr, w_xfer;
  assign w_claim = p_we && p_ad != '0;
  assign w_force = r_state == FORCE;
  assign w_grant_p = !w_force && w_claim;
  assign w_lr = !w_grant_p;
  assign w_xfer = !rst && l_valid && w_lr;
  assign l_ready = !rst && w_lr;
  assign p_stall = !rst && w_force;
  assign we3 = !rst && (w_grant_p || (l_valid && l_ad != '0));
  assign ad3 = w_grant_p ? p_ad : l_ad;
  assign wd3 = w_grant_p ? p_wd : l_wd;
  assign q_busy1 = !rst && r_pend[q_ad1];
  assign q_busy2 = !rst && r_pend[q_ad2];
  assign pending_any = !rst && |r_pend;
  always_comb begin
    w_state_nxt = NORMAL;
    w_cnt_nxt = '0;
    if (!w_force && l_valid && !w_lr) begin
      w_state_nxt = (r_cnt == LIM_M1) ? FORCE : NORMAL;
      w_cnt_nxt = (r_cnt == LIM_M1) ? 4'd0 : r_cnt + 4'd1;
    end
  end
  // issue set is applied after the commit clear so a same-register reissue stays pending
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_xfer) w_pend_nxt[l_ad] = 1'b0;
    if (iss_valid) w_pend_nxt[iss_ad] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NORMAL;
      r_cnt <= '0;
      r_pend <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_pend <= w_pend_nxt;
    end
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port (we3/ad3/wd3) of the 32-entry register file.
- Shares that port between the in-order pipeline writeback and one long-latency unit (mul/div/load) on a valid/ready handshake.
- Keeps a per-register pending scoreboard so decode can stall on operands whose long-latency result has not yet committed.
- Bounds starvation of the long-latency unit by stalling the pipeline for one cycle.

Parameters:
- A_WIDTH, 5, register address width; scoreboard has 2**A_WIDTH bits.
- D_WIDTH, 32, data width.
- STARVE_LIMIT, 3, consecutive blocked cycles of the long-latency unit before a forced grant (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- p_we  in  1  pipeline writeback request.
- p_ad  in  A_WIDTH  pipeline destination register.
- p_wd  in  D_WIDTH  pipeline write data.
- p_stall  out  1  pipeline must hold its writeback this cycle and re-present it next cycle.
- l_valid  in  1  long-latency result valid.
- l_ready  out  1  long-latency result accepted this cycle.
- l_ad  in  A_WIDTH  long-latency destination register.
- l_wd  in  D_WIDTH  long-latency result data.
- iss_valid  in  1  long-latency op issued this cycle; mark iss_ad pending.
- iss_ad  in  A_WIDTH  destination of the issued op.
- q_ad1  in  A_WIDTH  first operand query address.
- q_ad2  in  A_WIDTH  second operand query address.
- q_busy1  out  1  pending[q_ad1].
- q_busy2  out  1  pending[q_ad2].
- pending_any  out  1  OR of all pending bits.
- we3  out  1  register file write enable.
- ad3  out  A_WIDTH  register file write address.
- wd3  out  D_WIDTH  register file write data.

Behaviour:
- State: FSM {NORMAL, FORCE}; starvation counter cnt (4 bits); pending[2**A_WIDTH-1:0].
- Reset: state NORMAL, cnt=0, all pending=0.
- Outputs while rst=1: we3=0, l_ready=0, p_stall=0, q_busy1/2=0, pending_any=0.
- Write port path is combinational: zero latency from grant to we3/ad3/wd3. The RF commits at the same posedge.
- Pipeline claim: p_claim = p_we && p_ad!=0. Writes to x0 never claim the port.
- NORMAL state:
  - p_claim=1: grant pipeline. we3=1, ad3=p_ad, wd3=p_wd; l_ready=0; p_stall=0.
  - p_claim=0: l_ready=1. If l_valid=1: ad3=l_ad, wd3=l_wd, we3=(l_ad!=0). Otherwise we3=0.
- FORCE state:
  - p_stall=1, l_ready=1, long-latency unit granted as above. The pipeline request is ignored and not lost; the pipeline re-presents it.
  - Always returns to NORMAL on the next cycle with cnt=0, even if l_valid=0.
- Counter, NORMAL state only:
  - l_valid && !l_ready: cnt increments. If cnt==STARVE_LIMIT-1 at that edge, next state is FORCE and cnt resets to 0.
  - Otherwise cnt=0.
- Handshake rules:
  - Transfer occurs when l_valid && l_ready.
  - l_valid, l_ad and l_wd must stay stable until transfer.
  - l_ready does not depend on l_valid.
- Long-latency write to x0: accepted (l_ready=1), we3=0, no scoreboard change.
- Scoreboard:
  - On posedge, a transfer clears pending[l_ad].
  - iss_valid && iss_ad!=0 sets pending[iss_ad].
  - Set and clear on the same register in the same cycle: set wins (the new issue).
  - pending[0] is constant 0.
- Query outputs are combinational reads of the registered bits, with no bypass. q_busy stays 1 during the commit cycle and drops the cycle after, which matches the RF's write-then-read timing.
- Pipeline writes never touch the scoreboard. WAW avoidance is the issue logic's responsibility.
- Reset asserted mid-FORCE or with pending bits set: everything cleared on that edge. An in-flight l_valid result is treated as lost.

Test Plan:
- Reset with rst=1 for 2 cycles, arbitrary inputs -> we3=0, l_ready=0, p_stall=0, pending_any=0. After release, q_busy1/2=0 for all addresses.
- p_we=1, p_ad=5, p_wd=0xDEADBEEF; l_valid=0 -> same cycle we3=1, ad3=5, wd3=0xDEADBEEF. With p_ad=0 instead -> we3=0, l_ready=1.
- Issue iss_ad=7 at cycle 0. Long-latency result l_ad=7, l_wd=0x1234 with p_we=0 at cycle 3 -> q_busy1(q_ad1=7)=1 in cycles 1..3, we3=1/ad3=7 in cycle 3, q_busy1=0 from cycle 4.
- p_we=1 (p_ad=3) every cycle, l_valid=1 (l_ad=9) from cycle 0 -> l_ready=0 in cycles 0..2, FORCE in cycle 3 (p_stall=1, l_ready=1, ad3=9), pipeline granted again in cycle 4 with cnt=0.
- Same cycle: iss_valid=1, iss_ad=4 and transfer with l_ad=4 -> pending[4] remains 1 next cycle. l_ad=0 transfer -> we3=0, pending_any unchanged.
- FORCE entered, rst=1 on that cycle -> next cycle state NORMAL, p_stall=0, pending_any=0.
